sr_fetch_arbiter: RTL

SR_FETCH_ARBITER -- requirements
Module: sr_fetch_arbiter

---
 rtl/sr_fetch_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sr_fetch_arbiter.sv
//------------------------------------------------------------------------------
// sr_fetch_arbiter: two-stream instruction FIFOs with round-robin issue to decode
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_fetch_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [XLEN-1:0]            in0_addr,
  input  logic [XLEN-1:0]            in0_instr,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic [XLEN-1:0]            in1_addr,
  input  logic [XLEN-1:0]            in1_instr,
  input  logic [1:0]                 flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_addr,
  output logic                       out_tid,
  output logic [$clog2(DEPTH):0]     count0,
  output logic [$clog2(DEPTH):0]     count1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

  logic [1:0]                 in_valid;
  logic [1:0]                 in_ready;
  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0]                 elig;
  logic [1:0][XLEN-1:0]       in_addr;
  logic [1:0][XLEN-1:0]       in_instr;
  logic [1:0][2*XLEN-1:0]     head;
  logic [1:0][CW-1:0]         cnt;

  logic                       grant;
  logic                       last_grant_q, last_grant_d;
  logic                       lock_q, lock_d;
  logic                       lock_tid_q, lock_tid_d;

  assign in_valid = {in1_valid, in0_valid};
  assign in_addr  = {in1_addr, in0_addr};
  assign in_instr = {in1_instr, in0_instr};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_stream
      logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]      count_q, count_d;
      logic [2*XLEN-1:0]  mem_q [DEPTH];

      assign in_ready[i] = (count_q < CW'(DEPTH));
      assign push[i]     = in_valid[i] & in_ready[i] & ~flush[i];
      assign elig[i]     = (count_q != '0) & ~flush[i];
      assign head[i]     = mem_q[rd_ptr_q];
      assign cnt[i]      = count_q;

      // Flush wins over any push or pop on this stream in the same cycle.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush[i]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push[i]) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop[i])  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push[i], pop[i]})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push[i]) mem_q[wr_ptr_q] <= {in_addr[i], in_instr[i]};
      end
    end
  endgenerate

  assign in0_ready = in_ready[0];
  assign in1_ready = in_ready[1];
  assign count0    = cnt[0];
  assign count1    = cnt[1];
  assign out_valid = |elig;

  // A held lock keeps the presented stream stable; a flushed lock falls back to round-robin.
  always_comb begin
    grant = 1'b0;
    if (lock_q && elig[lock_tid_q]) grant = lock_tid_q;
    else if (&elig)                 grant = ~last_grant_q;
    else                            grant = elig[1];
  end

  always_comb begin
    pop          = 2'b00;
    last_grant_d = last_grant_q;
    lock_d       = out_valid & ~out_ready;
    lock_tid_d   = grant;
    if (out_valid && out_ready) begin
      pop[grant]   = 1'b1;
      last_grant_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_tid_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_tid_q   <= lock_tid_d;
    end
  end

  assign out_tid   = out_valid ? grant : 1'b0;
  assign out_addr  = out_valid ? head[grant][2*XLEN-1:XLEN] : '0;
  assign out_instr = out_valid ? head[grant][XLEN-1:0] : NOP;

endmodule

`default_nettype wire
